// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART.
// Holds the CPU bus addresses, the receive FSM state encoding and the
// bit positions of the receive status word.
package uart_pkg;

  localparam logic [31:0] UART_TX_ADDR      = 32'h0000_7000;
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_7004;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_7008;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Receive status word layout
  localparam int STAT_NE_BIT   = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVR_BIT  = 2;
  localparam int STAT_FERR_BIT = 3;
  localparam int STAT_BCNT_LSB = 4;
  localparam int STAT_CNT_LSB  = 8;

endpackage

// File: rtl/uart_rx_top_if.sv
// CPU-side bus of the UART receiver.
//   re      : read strobe, one clk cycle per access
//   address : byte address
//   dataOut : read data, combinational from address
//   rx_irq  : high while the receive FIFO holds a word
interface uart_rx_top_if;
  logic        re;
  logic [31:0] address;
  logic [31:0] dataOut;
  logic        rx_irq;

  modport master (output re, output address, input dataOut, input rx_irq);
  modport slave  (input re, input address, output dataOut, output rx_irq);
endinterface

// File: rtl/uart_rx_bit.sv
// Bit-level 8N1 receiver: two-flop synchroniser, 16x oversample tick
// generator and deframing FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : raw serial input, idle high
//   byte_valid   : one-cycle pulse when a byte with a good stop bit completes
//   byte_data    : received byte, valid with byte_valid
//   ferr_pulse   : one-cycle pulse when a stop bit samples low
module uart_rx_bit
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 54
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr_pulse
);

  logic        sync1_q, sync2_q;
  logic [15:0] tcnt_q, tcnt_d;
  logic        tick;
  rx_state_e   state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bit_q, bit_d;
  logic        brk_q, brk_d;
  logic [7:0]  shift_q, shift_d;

  // Free-running divider; never realigned to the start bit.
  assign tick   = (tcnt_q == 16'(BAUD_DIV - 1));
  assign tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
      state_q <= RX_IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      brk_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      brk_q   <= brk_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bit_d      = bit_q;
    brk_d      = brk_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    ferr_pulse = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (tick && !sync2_q) begin
          state_d = RX_START;
          sc_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          // Half a bit after detection: confirm the start bit is still low.
          if (sc_q == 4'd7) begin
            sc_d  = '0;
            bit_d = '0;
            state_d = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (sc_q == 4'd15) begin
            sc_d    = '0;
            shift_d = {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = RX_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (brk_q) begin
          // After a framing error, wait for the line to return high.
          if (sync2_q) begin
            brk_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (tick) begin
          if (sc_q == 4'd15) begin
            sc_d = '0;
            if (sync2_q) begin
              byte_valid = 1'b1;
              state_d    = RX_IDLE;
            end else begin
              ferr_pulse = 1'b1;
              brk_d      = 1'b1;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_rx_top.sv
// Memory-mapped UART receiver. Packs received bytes MSB-first into 32-bit
// words and buffers them in a FIFO read by the CPU.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : serial input, idle high
//   bus          : CPU read port (re, address, dataOut) and rx_irq
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 54,
  parameter int FIFO_AW  = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx,
  uart_rx_top_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ferr_pulse;

  uart_rx_bit #(.BAUD_DIV(BAUD_DIV)) u_bit (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ferr_pulse (ferr_pulse)
  );

  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        word_q, word_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ferr_q, ovr_q;
  logic [31:0]        mem_q [DEPTH];

  logic empty, full, sel_data, sel_stat, pop, push_req, push, ovr_set, stat_clr;
  logic [31:0] push_word, stat;
  logic [3:0]  cnt4;

  assign empty = (cnt_q == '0);
  // Count never exceeds DEPTH, so its top bit alone means full.
  assign full  = cnt_q[FIFO_AW];

  assign sel_data = (bus.address == UART_RX_DATA_ADDR);
  assign sel_stat = (bus.address == UART_RX_STAT_ADDR);
  assign pop      = bus.re && sel_data && !empty;
  assign stat_clr = bus.re && sel_stat;

  // Byte 3 bypasses the word register and goes straight into the FIFO.
  assign push_req  = byte_valid && (bcnt_q == 2'd3);
  assign push_word = {word_q, byte_data};
  assign push      = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;

  always_comb begin
    word_d = word_q;
    bcnt_d = bcnt_q;
    if (byte_valid) begin
      case (bcnt_q)
        2'd0:    word_d[23:16] = byte_data;
        2'd1:    word_d[15:8]  = byte_data;
        2'd2:    word_d[7:0]   = byte_data;
        default: word_d        = word_q;
      endcase
      bcnt_d = bcnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      // A set event in the clearing cycle wins.
      ferr_q <= ferr_pulse | (ferr_q & ~stat_clr);
      ovr_q  <= ovr_set    | (ovr_q  & ~stat_clr);
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (push) mem_q[wptr_q] <= push_word;
  end

  assign cnt4 = 4'(cnt_q);

  always_comb begin
    stat                          = '0;
    stat[STAT_CNT_LSB +: 4]       = cnt4;
    stat[STAT_BCNT_LSB +: 2]      = bcnt_q;
    stat[STAT_FERR_BIT]           = ferr_q;
    stat[STAT_OVR_BIT]            = ovr_q;
    stat[STAT_FULL_BIT]           = full;
    stat[STAT_NE_BIT]             = !empty;
  end

  always_comb begin
    bus.dataOut = '0;
    if (sel_data && !empty) bus.dataOut = mem_q[rptr_q];
    else if (sel_stat)      bus.dataOut = stat;
  end

  assign bus.rx_irq = !empty;

endmodule

// File: tb/tb_uart_rx_top.sv
module tb_uart_rx_top;

  localparam logic [31:0] A_TX   = 32'h0000_7000;
  localparam logic [31:0] A_DATA = 32'h0000_7004;
  localparam logic [31:0] A_STAT = 32'h0000_7008;
  localparam int BIT_CLK = 64;

  logic clk;
  logic reset_n;
  logic rx;
  int   checks;
  int   errors;

  uart_rx_top_if bus_if ();

  uart_rx_top #(.BAUD_DIV(4), .FIFO_AW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic do_re, output logic [31:0] d);
    @(negedge clk);
    bus_if.address = a;
    bus_if.re      = do_re;
    #1 d = bus_if.dataOut;
    @(posedge clk);
    #1 bus_if.re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.rx_irq !== 1'b0) begin
      $display("FAIL reset_irq got %b exp 0", bus_if.rx_irq); errors++;
    end
    bus_if.address = A_STAT;
    #1;
    checks++;
    if (bus_if.dataOut !== 32'h0) begin
      $display("FAIL reset_stat got %h exp 00000000", bus_if.dataOut); errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_rd(A_DATA, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL reset_data got %h exp 00000000", d); errors++;
    end
  endtask

  task automatic test_basic_word();
    logic [31:0] d;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    checks++;
    if (bus_if.rx_irq !== 1'b1) begin
      $display("FAIL word_irq got %b exp 1", bus_if.rx_irq); errors++;
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h101) begin
      $display("FAIL word_stat got %h exp 00000101", d); errors++;
    end
    bus_rd(A_TX, 1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL other_addr got %h exp 00000000", d); errors++;
    end
    bus_rd(A_DATA, 1'b1, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      $display("FAIL word_data got %h exp deadbeef", d); errors++;
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL word_stat_after got %h exp 00000000", d); errors++;
    end
    bus_rd(A_DATA, 1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL empty_pop got %h exp 00000000", d); errors++;
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL empty_pop_stat got %h exp 00000000", d); errors++;
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL glitch_stat got %h exp 00000000", d); errors++;
    end
  endtask

  task automatic test_ferr();
    logic [31:0] d;
    send_byte(8'h55, 1'b0);
    bus_rd(A_STAT, 1'b1, d);
    checks++;
    if (d !== 32'h008) begin
      $display("FAIL ferr_stat got %h exp 00000008", d); errors++;
    end
    bus_rd(A_STAT, 1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL ferr_clear got %h exp 00000000", d); errors++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h99, 1'b1);
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h111) begin
      $display("FAIL pre_reset_stat got %h exp 00000111", d); errors++;
    end
    // Low start bit and low data bits 0..3, reset in the middle of bit 3.
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK * 4 + BIT_CLK / 2) @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.rx_irq !== 1'b0) begin
      $display("FAIL midreset_irq got %b exp 0", bus_if.rx_irq); errors++;
    end
    bus_if.address = A_STAT;
    #1;
    checks++;
    if (bus_if.dataOut !== 32'h0) begin
      $display("FAIL midreset_stat got %h exp 00000000", bus_if.dataOut); errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h101) begin
      $display("FAIL postreset_stat got %h exp 00000101", d); errors++;
    end
    bus_rd(A_DATA, 1'b1, d);
    checks++;
    if (d !== 32'h01020304) begin
      $display("FAIL postreset_data got %h exp 01020304", d); errors++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int w = 0; w < 9; w++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'(w), 1'b1);
    end
    bus_rd(A_STAT, 1'b1, d);
    checks++;
    if (d !== 32'h807) begin
      $display("FAIL ovr_stat got %h exp 00000807", d); errors++;
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h803) begin
      $display("FAIL ovr_clear got %h exp 00000803", d); errors++;
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] d;
    logic [31:0] popped;
    logic [31:0] exp_w;
    logic        found;
    found  = 1'b0;
    popped = 32'hFFFF_FFFF;
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    fork
      send_byte(8'hD4, 1'b1);
      begin
        for (int n = 0; n < 2000 && !found; n++) begin
          @(negedge clk);
          if (dut.u_bit.byte_valid) found = 1'b1;
        end
        if (found) begin
          bus_if.address = A_DATA;
          bus_if.re      = 1'b1;
          #1 popped = bus_if.dataOut;
          @(posedge clk);
          #1 bus_if.re = 1'b0;
        end
      end
    join
    checks++;
    if (!found) begin
      $display("FAIL pushpop_timeout got 0 exp byte completion"); errors++;
    end
    checks++;
    if (popped !== 32'h0) begin
      $display("FAIL pushpop_head got %h exp 00000000", popped); errors++;
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h803) begin
      $display("FAIL pushpop_stat got %h exp 00000803", d); errors++;
    end
    for (int i = 1; i <= 8; i++) begin
      exp_w = (i == 8) ? 32'hA1B2C3D4 : 32'(i);
      bus_rd(A_DATA, 1'b1, d);
      checks++;
      if (d !== exp_w) begin
        $display("FAIL fifo_word%0d got %h exp %h", i, d, exp_w); errors++;
      end
    end
    bus_rd(A_STAT, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL drained_stat got %h exp 00000000", d); errors++;
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rx             = 1'b1;
    reset_n        = 1'b0;
    bus_if.re      = 1'b0;
    bus_if.address = 32'h0;
    test_reset();
    test_basic_word();
    test_glitch();
    test_ferr();
    test_reset_midframe();
    test_overflow();
    test_full_pushpop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Receive-side companion to the memory-mapped UART transmitter. It samples the serial `rx` line at 16x oversampling and deframes 8N1 bytes. Every four received bytes are packed into one 32-bit word, most significant byte first, matching the byte order the transmitter uses for its word-to-byte mux. Words are buffered in a small synchronous FIFO that the CPU reads over the same data-memory bus as the TX port, at 0x0000_7004 (data) and 0x0000_7008 (status).

## Interface
- `BAUD_DIV`, 54: clk cycles per oversample tick (100 MHz / (115200·16)); legal range 2..65535.
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW words.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `re`  in  1  CPU read strobe, one `clk` cycle per access.
- `address`  in  32  CPU byte address.
- `dataOut`  out  32  read data, combinational from `address`.
- `rx_irq`  out  1  high while the FIFO is non-empty.

## Operation
- **Input sync:** `rx` passes through two flops; both reset to 1. The FSM sees only the synced value.
- **Tick generator:** counter runs 0..BAUD_DIV-1. `tick` is high for 1 cycle at BAUD_DIV-1. The counter free-runs and is not restarted by start-bit detection.
- **FSM** (IDLE, START, DATA, STOP), with a 4-bit tick counter `sc` and a 3-bit bit index:
  - IDLE: synced rx==0 on a tick → START, `sc`=0.
  - START: on the tick where `sc` reaches 7, rx==0 → DATA with `sc`=0; rx==1 → IDLE (glitch rejected).
  - DATA: sample on the tick where `sc` reaches 15. Bits arrive LSB first, into shift[7]. After bit 7 → STOP.
  - STOP: sample at `sc`==15. rx==1 → byte valid for 1 cycle, → IDLE. rx==0 → discard the byte, set `ferr`, remain in STOP until rx==1, then → IDLE.
- **Packer:** 2-bit `bcnt`. Byte k goes into word[31-8k : 24-8k]. On byte 3 the word is pushed to the FIFO and `bcnt` wraps to 0. A framing error does not advance `bcnt`.
- **FIFO push when full:** the word is dropped, `ovr` is set, and FIFO contents are unchanged.
- **Reads:**
  - 0x7004: `dataOut` = head word, or 0 if empty. `re` pops when non-empty; `re` on empty has no effect.
  - 0x7008: `dataOut` = {20'b0, count[3:0] at [11:8], 2'b0, bcnt at [5:4], ferr [3], ovr [2], full [1], ~empty [0]}. `re` clears `ferr` and `ovr`. If an event sets one of these in the same cycle, set wins.
  - Any other address: `dataOut` = 0, and `re` has no effect.
- **Simultaneous push and pop:**
  - Full: pop and push both proceed; count unchanged; no overrun.
  - Empty: push only.

## Timing
- **Reset values** (asynchronous on reset_n=0): FIFO pointers and count 0, `bcnt` 0, `ferr`/`ovr` 0, FSM IDLE, sync flops 1, tick counter 0, `rx_irq` 0.
- **Receive latency:** a word is visible at 0x7004 and `rx_irq` rises 1 clk after the stop-bit sample of byte 3.
- **Sample point:** mid-bit, 8 ticks after start detection, then every 16 ticks. Detection uncertainty is 2 clk for the sync stages plus up to 1 tick.
- **Read timing:** `dataOut` is valid in the same cycle as `address`. A pop takes effect at the clk edge ending the `re` cycle.
- **Reset mid-frame:** the partial byte and partial word are lost. The next complete frame is received normally.

## Structure
- **Shared package `uart_pkg`:**
  - address constants UART_TX_ADDR=32'h0000_7000, UART_RX_DATA_ADDR=32'h0000_7004, UART_RX_STAT_ADDR=32'h0000_7008
  - rx FSM state encoding (2-bit)
  - status bit positions
- **Sub-module `uart_rx_bit`:** sync flops, tick generator and FSM; outputs `byte_valid`, `byte_data[7:0]`, `ferr_pulse`.
- **Top level:** packer, FIFO and bus decode stay in the top.

## Test plan
All scenarios use BAUD_DIV=4, so 1 bit = 64 clk.
- Frames 0xDE, 0xAD, 0xBE, 0xEF → `rx_irq`=1, status=0x101; read 0x7004 → 0xDEADBEEF; status then 0x000.
- rx low for 20 clk, then high → no byte; status `bcnt`=0, `ferr`=0.
- Frame 0x55 with stop bit 0 → status bit3=1, `bcnt`=0; status read returns 0x008, next status read returns 0x000.
- 9 words (36 bytes, word i = 0x0000_0000+i), no reads → count=8, `ovr`=1, full=1; the first pop returns word 0 and words 0..7 are intact.
- reset_n low during data bit 3 of a frame → all outputs at reset values; the following 4 frames 0x01, 0x02, 0x03, 0x04 read as 0x01020304.
- FIFO full, `re` at 0x7004 in the same cycle as the 4th byte completes → count stays 8, `ovr`=0, newest word appears at tail.
